// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver that pushes {frm_err, par_err, data} into a first-word-fall-through FIFO.
// The PS/2 clock is inhibited on a host hold request and, optionally, while the FIFO is full.
`timescale 1ns/1ps
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT_CYC  = 100000,
  parameter int AUTO_INHIBIT = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ps2_clk_i,
  input  logic                            ps2_data_i,
  output logic                            ps2_clk_o,
  output logic                            ps2_clk_w,
  input  logic                            hold_req,
  input  logic                            rx_en,
  input  logic                            rd_en,
  output logic [7:0]                      rd_data,
  output logic                            rd_par_err,
  output logic                            rd_frm_err,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            overflow,
  output logic                            timeout,
  output logic                            rx_idle,
  input  logic                            clr_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, HOLD = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic          ps2_data_p0, ps2_data_p1;
  logic          fall;
  logic [10:0]   frame, frame_sh;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic          start_frame, stop_edge, to_hit;
  logic [9:0]    push_word;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, wr_ok, ovf_set;

  // Stage p0/p1: two-flop synchronisers (idle level 1); p2 keeps the previous synchronised clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk_i;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= ps2_data_i;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  assign fall      = ps2_clk_p2 & ~ps2_clk_p1;
  assign frame_sh  = {ps2_data_p1, frame[10:1]};
  assign push_word = {frame_sh[0] | ~frame_sh[10], ~(^frame_sh[9:1]), frame_sh[8:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    stop_edge   = 1'b0;
    to_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (hold_req) begin
          state_nxt = HOLD;
        end else if (fall && !ps2_data_p1 && rx_en) begin
          state_nxt   = RECV;
          start_frame = 1'b1;
        end
      end
      RECV: begin
        if (fall) begin
          if (bit_cnt == 4'd10) begin
            stop_edge = 1'b1;
            state_nxt = IDLE;
          end
        end else if (to_cnt == TW'(TIMEOUT_CYC)) begin
          to_hit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (!hold_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1 -> frame: shift register is filled from the top so the start bit lands in bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame   <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else if (start_frame) begin
      frame   <= {ps2_data_p1, 10'd0};
      bit_cnt <= 4'd1;
      to_cnt  <= '0;
    end else if (stop_edge || to_hit) begin
      frame   <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else if (state == RECV) begin
      if (fall) begin
        frame   <= frame_sh;
        bit_cnt <= bit_cnt + 4'd1;
        to_cnt  <= '0;
      end else begin
        to_cnt  <= to_cnt + TW'(1);
      end
    end
  end

  assign pop     = rd_en & ~empty;
  assign wr_ok   = stop_edge & (~full | pop);
  assign ovf_set = stop_edge & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_ok && !pop)      count <= count + CW'(1);
      else if (!wr_ok && pop) count <= count - CW'(1);
      // A drop in the same cycle as a clear leaves the flag set.
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign {rd_frm_err, rd_par_err, rd_data} = empty ? 10'd0 : mem[rd_ptr];

  assign ps2_clk_o = 1'b0;
  assign ps2_clk_w = (state == HOLD) | ((AUTO_INHIBIT != 0) & (state == IDLE) & full);
  assign timeout   = to_hit;
  assign rx_idle   = (state == IDLE);

endmodule
